// File: rtl/d_ff.sv
// d_ff: parameterised D register / delay line with complementary outputs.
// Build option DFF_EDGE_DET_EN adds registered per-bit rise/fall pulse outputs.
module d_ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter int unsigned      STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  input  logic             clk,
  input  logic             rst
`ifdef DFF_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  // Reject unsupported pipeline depths at elaboration time.
  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("d_ff: STAGES must be in 1..16");
  end

  logic [WIDTH-1:0] stage [STAGES];

  // Shift chain; reset discards every in-flight word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= RESET_VALUE;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Both polarities come from the same flop, so they can never agree.
  assign q    = stage[STAGES-1];
  assign qbar = ~stage[STAGES-1];

`ifdef DFF_EDGE_DET_EN
  logic [WIDTH-1:0] q_prev;

  // q_prev is loaded with the reset value so the reset load itself never pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_prev <= RESET_VALUE;
      rise   <= '0;
      fall   <= '0;
    end else begin
      q_prev <= q;
      rise   <= q & ~q_prev;
      fall   <= ~q & q_prev;
    end
  end
`endif

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: table-driven check of a plain DFF (W1/S1) and a 3-deep 4-bit delay line
// run side by side, plus hand sequences for mid-cycle glitch and late-setup capture.
module tb_d_ff;

  logic       clk = 1'b0;
  logic       rst;
  logic       d1;
  logic       q1, qbar1;
  logic [3:0] d4, q4, qbar4;
`ifdef DFF_EDGE_DET_EN
  logic       rise1, fall1;
  logic [3:0] rise4, fall4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  d_ff #(.WIDTH(1), .STAGES(1)) u_dff1 (
    .d(d1), .q(q1), .qbar(qbar1), .clk(clk), .rst(rst)
`ifdef DFF_EDGE_DET_EN
    , .rise(rise1), .fall(fall1)
`endif
  );

  d_ff #(.WIDTH(4), .STAGES(3), .RESET_VALUE(4'h6)) u_dff4 (
    .d(d4), .q(q4), .qbar(qbar4), .clk(clk), .rst(rst)
`ifdef DFF_EDGE_DET_EN
    , .rise(rise4), .fall(fall4)
`endif
  );

  typedef struct {
    logic       rst;
    logic       d1;
    logic [3:0] d4;
    logic       q1;
    logic [3:0] q4;
    logic       rise;
    logic       fall;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic a, input logic [3:0] b,
                              input logic eq1, input logic [3:0] eq4,
                              input logic er, input logic ef);
    vec_t v;
    v.rst = r; v.d1 = a; v.d4 = b; v.q1 = eq1; v.q4 = eq4; v.rise = er; v.fall = ef;
    return v;
  endfunction

  initial begin
    //              rst  d1    d4    q1    q4    rise  fall
    vecs[0]  = mk(1'b0, 1'b1, 4'hA, 1'b0, 4'h6, 1'b0, 1'b0); // reset with d=1
    vecs[1]  = mk(1'b0, 1'b1, 4'hA, 1'b0, 4'h6, 1'b0, 1'b0); // still reset, unchanged
    vecs[2]  = mk(1'b1, 1'b1, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 4'h5, 1'b0, 4'h6, 1'b1, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 4'hC, 1'b0, 4'hA, 1'b0, 1'b1); // A after 3rd edge
    vecs[5]  = mk(1'b1, 1'b1, 4'h3, 1'b1, 4'h5, 1'b0, 1'b0); // 5 after 4th edge
    vecs[6]  = mk(1'b1, 1'b1, 4'hF, 1'b1, 4'hC, 1'b1, 1'b0); // d==q holds
    vecs[7]  = mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h3, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 4'hA, 1'b0, 4'hF, 1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 4'hC, 1'b1, 4'hA, 1'b1, 1'b0); // pipe holds C,5,A
    vecs[11] = mk(1'b0, 1'b1, 4'h9, 1'b0, 4'h6, 1'b0, 1'b0); // reset wins over d
    vecs[12] = mk(1'b1, 1'b1, 4'h1, 1'b1, 4'h6, 1'b0, 1'b0); // no fall from reset load
    vecs[13] = mk(1'b1, 1'b0, 4'h2, 1'b0, 4'h6, 1'b1, 1'b0); // old 5/C never reappear
    vecs[14] = mk(1'b1, 1'b0, 4'h4, 1'b0, 4'h1, 1'b0, 1'b1);
    vecs[15] = mk(1'b1, 1'b1, 4'h8, 1'b1, 4'h2, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst;
      d1  = vecs[i].d1;
      d4  = vecs[i].d4;
      @(posedge clk);
      #1;
      check("q1",    i, {3'b0, q1},    {3'b0, vecs[i].q1});
      check("qbar1", i, {3'b0, qbar1}, {3'b0, ~vecs[i].q1});
      check("q4",    i, q4,            vecs[i].q4);
      check("qbar4", i, qbar4,         ~vecs[i].q4);
`ifdef DFF_EDGE_DET_EN
      check("rise1", i, {3'b0, rise1}, {3'b0, vecs[i].rise});
      check("fall1", i, {3'b0, fall1}, {3'b0, vecs[i].fall});
`endif
    end

    // Capture a 0 to set up the glitch test.
    d1 = 1'b0;
    d4 = 4'h0;
    @(posedge clk);
    #1;
    check("pre_glitch_q1", 0, {3'b0, q1}, 4'h0);

    // A pulse wholly between edges must not be captured.
    #2 d1 = 1'b1;
    #3 d1 = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_q1",    0, {3'b0, q1},    4'h0);
    check("glitch_qbar1", 0, {3'b0, qbar1}, 4'h1);

    // d set 2 ns before the edge is captured at that edge.
    #7 d1 = 1'b1;
    @(posedge clk);
    #1;
    check("late_q1",    0, {3'b0, q1},    4'h1);
    check("late_qbar1", 0, {3'b0, qbar1}, 4'h0);

    // Next edge with d=0 brings q back down.
    d1 = 1'b0;
    @(posedge clk);
    #1;
    check("drop_q1",    0, {3'b0, q1},    4'h0);
    check("drop_qbar1", 0, {3'b0, qbar1}, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_ff.md
Name: d_ff

Overview:
- Parameterised D-type register with complementary outputs. It is the basic sequential storage primitive of the seqlogic library.
- Captures d on the rising clock edge and drives q and its inverse qbar.
- Reset is synchronous and active-low.
- Optional STAGES parameter turns it into a shift/delay pipeline of identical flops. An optional edge-detect output set can be compiled in.

Parameters:
- WIDTH, 1, bit width of d, q and qbar.
- STAGES, 1, number of cascaded register stages between d and q; legal range 1..16.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every stage while reset is asserted.

Ports:
- clk  input  1  clock; all state changes on its rising edge only.
- rst  input  1  reset, synchronous, active-low (0 = reset asserted), sampled at rising clk.
- d  input  WIDTH  data in.
- q  output  WIDTH  registered data out (last stage).
- qbar  output  WIDTH  bitwise complement of q.
- Declaration order (positional use): d, q, qbar, clk, rst. With DFF_EDGE_DET_EN, rise and fall are appended after rst.

Behaviour:
- One clock domain. No asynchronous paths; rst has no effect between clock edges.
- Internal state: stage[0..STAGES-1], each WIDTH bits.
- At rising clk with rst==0: every stage <= RESET_VALUE, so q = RESET_VALUE and qbar = ~RESET_VALUE after that edge.
- At rising clk with rst==1:
  - stage[0] <= d.
  - stage[i] <= stage[i-1] for i >= 1.
- q = stage[STAGES-1]. qbar = ~stage[STAGES-1].
  - qbar is derived combinationally from the same register, so q and qbar are never equal in any bit, including the reset cycle.
- Latency: d sampled at edge N appears on q after edge N+STAGES-1.
  - STAGES=1 gives a plain DFF: q updates at the same edge d is sampled.
- Before the first reset edge: q and qbar are X in simulation. No power-up value is guaranteed.
- d changing between edges has no effect. Only the value present at the rising edge is captured.
- d equal to the current q at an edge: q holds (no glitch on qbar).
- Reset mid-operation: all in-flight data in every stage is discarded at the reset edge.
  - The first post-reset sample is the d present at the first edge with rst==1.
- Reset deasserted and d applied in the same cycle: reset wins for that edge. d is captured at the next edge.
- STAGES outside 1..16: elaboration error via generate-time check.

Optional Feature:
- Macro: DFF_EDGE_DET_EN.
- Defined: adds outputs rise [WIDTH] and fall [WIDTH], both registered.
  - rise[i]=1 for exactly one cycle after q[i] transitions 0->1.
  - fall[i]=1 for exactly one cycle after q[i] transitions 1->0.
  - Both are cleared to 0 on reset. No pulse is generated by the reset load itself.
  - Adds one cycle of latency relative to q.
- Undefined: rise/fall ports and their logic are absent. Port list is exactly d, q, qbar, clk, rst.

Test Plan:
- Reset: rst=0 held over 2 rising edges with d=1, WIDTH=1, STAGES=1 -> q=0, qbar=1 after the first edge; unchanged after the second.
- Capture: rst=1, d=1 set 2 ns before an edge -> q=1, qbar=0 after that edge. d=0 before the next edge -> q=0, qbar=1.
- Mid-cycle glitch: d pulses 0->1->0 entirely between two edges -> q stays 0.
- Pipeline, STAGES=3, WIDTH=4: d=4'hA at edge 1, 4'h5 at edge 2 -> q=4'hA after edge 3, 4'h5 after edge 4; qbar=4'h5 then 4'hA.
- Reset mid-pipeline: STAGES=3 loaded with A,5,C, then rst=0 for one edge -> q=RESET_VALUE; old data never reappears on later edges.
- DFF_EDGE_DET_EN, WIDTH=1: q sequence 0,1,1,0 -> rise=1 for one cycle after the 0->1, fall=1 for one cycle after the 1->0; both 0 during and after reset.
